// File: rtl/sa_feed_pkg.sv
// sa_feed_pkg: shared state type, default sizes and width helpers
// for the systolic-array skew feeder (sa_skew_feeder + sa_feed_lane).
package sa_feed_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} feed_state_e;

    localparam int unsigned SA_LANES  = 25;
    localparam int unsigned SA_DATA_W = 8;
    localparam int unsigned SA_ADDR_W = 10;
    localparam int unsigned LANE_W    = $clog2(SA_LANES);

    function automatic int unsigned lane_w(input int unsigned lanes);
        return $clog2(lanes);
    endfunction

    // Tick counter width: burst length plus the largest lane skew.
    function automatic int unsigned cnt_w(input int unsigned addr_w,
                                          input int unsigned lanes);
        return addr_w + $clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/sa_feed_lane.sv
// sa_feed_lane: one SA row of the skew feeder. Decides whether the
// current tick falls in this lane's read window, drives the BRAM read
// and address, and registers the returned data as the beat to the SA.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   clr_i                   burst start: clear address, data and flags
//   abort_i                 drop everything in flight
//   step_i                  tick advance qualifier from the top
//   sa_ready_i              SA accepts the current beat
//   mode_i, len_i, act_i    latched burst configuration
//   t_i                     tick counter
//   rd_data_i               BRAM data, one cycle after rden_o
//   rden_o, addr_o          BRAM read port
//   valid_o, data_o         beat to the SA
//   last_o                  final element of the burst is on the beat
//   busy_o                  read or beat still in flight
module sa_feed_lane
    import sa_feed_pkg::*;
#(
    parameter int unsigned DATA_W = SA_DATA_W,
    parameter int unsigned ADDR_W = SA_ADDR_W,
    parameter int unsigned LW     = LANE_W,
    parameter int unsigned CNT_W  = cnt_w(SA_ADDR_W, SA_LANES),
    parameter int unsigned IDX    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              abort_i,
    input  logic              step_i,
    input  logic              sa_ready_i,
    input  logic              mode_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [LW:0]       act_i,
    input  logic [CNT_W-1:0]  t_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              rden_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              busy_o
);

    localparam logic [LW:0]      IDX_L = (LW+1)'(IDX);
    localparam logic [CNT_W-1:0] IDX_T = CNT_W'(IDX);

    logic [CNT_W-1:0]  off;
    logic [CNT_W-1:0]  len_t;
    logic [CNT_W-1:0]  rel;
    logic              lane_en;
    logic              in_win;
    logic              is_last;

    logic [ADDR_W-1:0] addr_q;
    logic              pend_q;
    logic              pend_last_q;
    logic              skid_v_q;
    logic [DATA_W-1:0] skid_q;
    logic              skid_last_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    assign off     = mode_i ? '0 : IDX_T;
    assign len_t   = CNT_W'(len_i);
    assign rel     = t_i - off;
    assign lane_en = IDX_L < act_i;
    assign in_win  = (t_i >= off) && (rel < len_t);
    assign is_last = (rel == len_t - 1'b1);

    assign rden_o  = step_i & lane_en & in_win;
    assign addr_o  = rden_o ? rel[ADDR_W-1:0] : addr_q;

    // Reads are only issued while the SA is ready, but the beat from the
    // previous read may still be stalled when the next data returns. The
    // one-entry skid catches that data while outputs are frozen; a second
    // overflow cannot occur because no read is issued while ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_q      <= '0;
            skid_last_q <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
        end else if (abort_i) begin
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            skid_v_q    <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else if (clr_i) begin
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            skid_v_q    <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            if (rden_o) begin
                addr_q <= rel[ADDR_W-1:0];
            end
            pend_q      <= rden_o;
            pend_last_q <= rden_o & is_last;
            if (sa_ready_i) begin
                if (skid_v_q) begin
                    data_q   <= skid_q;
                    last_q   <= skid_last_q;
                    valid_q  <= 1'b1;
                    skid_v_q <= 1'b0;
                end else if (pend_q) begin
                    data_q  <= rd_data_i;
                    last_q  <= pend_last_q;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            end else if (pend_q) begin
                skid_q      <= rd_data_i;
                skid_last_q <= pend_last_q;
                skid_v_q    <= 1'b1;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = valid_q & last_q;
    assign busy_o  = pend_q | skid_v_q | valid_q;

endmodule

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: reads LANES input-buffer banks and drives diagonally
// skewed (or aligned) row data into the systolic array west edge.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_i, abort_i  burst control pulses (abort wins)
//   mode_i            0 = skew lane i by i ticks, 1 = aligned
//   burst_len_i       elements per lane, 0..2**ADDR_W
//   active_lanes_i    lanes used, 1..LANES
//   busy_o, done_o    burst status / one-cycle completion pulse
//   buff_rden_o/addr  per-lane BRAM read port
//   buff_data_i       per-lane BRAM data, one cycle after rden
//   weight_ready_i    weights resident; low pauses new reads
//   sa_ready_i        SA accepts beats; low freezes the feeder
//   data_valid_o      per-lane beat valid
//   sa_data_o         per-lane beat data
//   burst_last_o      final beat of the burst is on the outputs
module sa_skew_feeder
    import sa_feed_pkg::*;
#(
    parameter int unsigned LANES  = SA_LANES,
    parameter int unsigned DATA_W = SA_DATA_W,
    parameter int unsigned ADDR_W = SA_ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic                           mode_i,
    input  logic [ADDR_W:0]                burst_len_i,
    input  logic [$clog2(LANES):0]         active_lanes_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [LANES-1:0]               buff_rden_o,
    output logic [LANES-1:0][ADDR_W-1:0]   buff_addr_o,
    input  logic [LANES-1:0][DATA_W-1:0]   buff_data_i,
    input  logic                           weight_ready_i,
    input  logic                           sa_ready_i,
    output logic [LANES-1:0]               data_valid_o,
    output logic [LANES-1:0][DATA_W-1:0]   sa_data_o,
    output logic                           burst_last_o
);

    localparam int unsigned LW = lane_w(LANES);
    localparam int unsigned CW = cnt_w(ADDR_W, LANES);

    feed_state_e     state_q;
    feed_state_e     state_d;

    logic            mode_q;
    logic [ADDR_W:0] len_q;
    logic [LW:0]     act_q;
    logic [CW-1:0]   t_q;
    logic [CW-1:0]   span;
    logic [CW-1:0]   t_end;

    logic            start_acc;
    logic            abort_eff;
    logic            step;
    logic            tick_end;
    logic            drained;

    logic [LANES-1:0] lane_busy;
    logic [LANES-1:0] lane_last;

    assign abort_eff = abort_i & (state_q != IDLE);
    assign start_acc = start_i & ~abort_i & (state_q == IDLE);
    // Abort also blocks the read that would otherwise issue this cycle.
    assign step      = (state_q == RUN) & weight_ready_i
                     & sa_ready_i & ~abort_i;

    assign span     = mode_q ? '0 : CW'(act_q) - 1'b1;
    assign t_end    = CW'(len_q) - 1'b1 + span;
    assign tick_end = step & (t_q == t_end);
    assign drained  = ~|lane_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = (burst_len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (tick_end) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (drained) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            len_q  <= '0;
            act_q  <= '0;
            t_q    <= '0;
        end else if (start_acc) begin
            mode_q <= mode_i;
            len_q  <= burst_len_i;
            act_q  <= active_lanes_i;
            t_q    <= '0;
        end else if (step) begin
            t_q <= t_q + 1'b1;
        end
    end

    // Aligned mode: every active lane carries its last element together.
    always_comb begin
        burst_last_o = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (mode_q || act_q == (LW+1)'(i + 1)) begin
                burst_last_o = burst_last_o | lane_last[i];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sa_feed_lane #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .LW     (LW),
            .CNT_W  (CW),
            .IDX    (g)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_i      (start_acc),
            .abort_i    (abort_eff),
            .step_i     (step),
            .sa_ready_i (sa_ready_i),
            .mode_i     (mode_q),
            .len_i      (len_q),
            .act_i      (act_q),
            .t_i        (t_q),
            .rd_data_i  (buff_data_i[g]),
            .rden_o     (buff_rden_o[g]),
            .addr_o     (buff_addr_o[g]),
            .valid_o    (data_valid_o[g]),
            .data_o     (sa_data_o[g]),
            .last_o     (lane_last[g]),
            .busy_o     (lane_busy[g])
        );
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb_sa_skew_feeder: directed bench for sa_skew_feeder with a BRAM
// model, per-lane beat scoreboard and cycle-exact timing checks.
module tb_sa_skew_feeder;

    localparam int L  = 25;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int LW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic mode = 1'b0;
    logic wr = 1'b1;
    logic sr = 1'b1;
    logic [AW:0] blen = '0;
    logic [LW:0] act = '0;

    logic busy, done, blast;
    logic [L-1:0] rden, dvalid;
    logic [L-1:0][AW-1:0] baddr;
    logic [L-1:0][DW-1:0] bdata, sdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int s_cyc = 0;
    bit rnd_en = 1'b0;

    int rd_cnt[L];
    int exp_addr[L];
    int beat_n[L];
    int first_rd[L];
    int last_v[L];
    logic hold_p[L];
    logic [DW-1:0] hold_d[L];
    int last_cnt, last_cyc, done_cnt, done_cyc, stall_rd;
    int sum;

    sa_skew_feeder u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .mode_i         (mode),
        .burst_len_i    (blen),
        .active_lanes_i (act),
        .busy_o         (busy),
        .done_o         (done),
        .buff_rden_o    (rden),
        .buff_addr_o    (baddr),
        .buff_data_i    (bdata),
        .weight_ready_i (wr),
        .sa_ready_i     (sr),
        .data_valid_o   (dvalid),
        .sa_data_o      (sdata),
        .burst_last_o   (blast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] bmem(input int l, input int a);
        return DW'(l * 29 + a * 3 + 7);
    endfunction

    // BRAM banks: data one cycle after rden, junk otherwise.
    always @(posedge clk) begin
        for (int l = 0; l < L; l++) begin
            bdata[l] <= rden[l] ? bmem(l, int'(baddr[l])) : 8'h5A;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_en) sr = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        for (int l = 0; l < L; l++) begin
            rd_cnt[l] = 0;
            exp_addr[l] = 0;
            beat_n[l] = 0;
            first_rd[l] = -1;
            last_v[l] = -1;
            hold_p[l] = 1'b0;
            hold_d[l] = '0;
        end
        last_cnt = 0;
        last_cyc = -1;
        done_cnt = 0;
        done_cyc = -1;
        stall_rd = 0;
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (blast && sr) begin
            last_cnt++;
            last_cyc = cyc;
        end
        if (|rden && !wr) stall_rd++;
        for (int l = 0; l < L; l++) begin
            if (rden[l]) begin
                rd_cnt[l]++;
                if (first_rd[l] < 0) first_rd[l] = cyc;
                chk("addr", 64'(baddr[l]), 64'(exp_addr[l]));
                exp_addr[l]++;
            end
            if (hold_p[l]) begin
                chk("hold_v", 64'(dvalid[l]), 64'd1);
                chk("hold_d", 64'(sdata[l]), 64'(hold_d[l]));
            end
            hold_p[l] = dvalid[l] & !sr;
            hold_d[l] = sdata[l];
            if (dvalid[l] && sr) begin
                chk("beat", 64'(sdata[l]), 64'(bmem(l, beat_n[l])));
                beat_n[l]++;
                last_v[l] = cyc;
            end
        end
    end

    task automatic start_burst(input logic m, input int n, input int a);
        @(posedge clk); #1;
        mode = m;
        blen = (AW+1)'(n);
        act = (LW+1)'(a);
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        clr_stats();
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rden", 64'(rden), 64'd0);
        chk("rst_addr", 64'(|baddr), 64'd0);
        chk("rst_valid", 64'(dvalid), 64'd0);
        chk("rst_data", 64'(|sdata), 64'd0);
        chk("rst_last", 64'(blast), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // skewed windows, 25 lanes, burst 4
        clr_stats();
        start_burst(1'b0, 4, 25);
        wait_idle(200);
        for (int l = 0; l < L; l++) begin
            chk("t1_first", 64'(first_rd[l]), 64'(s_cyc + 1 + l));
            chk("t1_rd", 64'(rd_cnt[l]), 64'd4);
            chk("t1_beats", 64'(beat_n[l]), 64'd4);
        end
        chk("t1_l24_cyc", 64'(last_v[24]), 64'(s_cyc + 30));
        chk("t1_last_cyc", 64'(last_cyc), 64'(s_cyc + 30));
        chk("t1_last_n", 64'(last_cnt), 64'd1);
        chk("t1_done_cyc", 64'(done_cyc), 64'(s_cyc + 32));
        chk("t1_done_n", 64'(done_cnt), 64'd1);

        // aligned, 9 lanes, burst 8
        clr_stats();
        start_burst(1'b1, 8, 9);
        wait_idle(200);
        for (int l = 0; l < L; l++) begin
            chk("t2_rd", 64'(rd_cnt[l]), (l < 9) ? 64'd8 : 64'd0);
            chk("t2_beats", 64'(beat_n[l]), (l < 9) ? 64'd8 : 64'd0);
            if (l < 9) chk("t2_first", 64'(first_rd[l]), 64'(s_cyc + 1));
        end
        chk("t2_idle_data", 64'(|sdata[L-1:9]), 64'd0);
        chk("t2_last_cyc", 64'(last_cyc), 64'(s_cyc + 10));
        chk("t2_last_n", 64'(last_cnt), 64'd1);
        chk("t2_done_cyc", 64'(done_cyc), 64'(s_cyc + 12));
        chk("t2_done_n", 64'(done_cnt), 64'd1);

        // random SA back-pressure, burst 16
        clr_stats();
        rnd_en = 1'b1;
        start_burst(1'b0, 16, 25);
        wait_idle(3000);
        rnd_en = 1'b0;
        sr = 1'b1;
        for (int l = 0; l < L; l++) begin
            chk("t3_rd", 64'(rd_cnt[l]), 64'd16);
            chk("t3_beats", 64'(beat_n[l]), 64'd16);
        end
        chk("t3_last_n", 64'(last_cnt), 64'd1);
        chk("t3_done_n", 64'(done_cnt), 64'd1);

        // weight stall for 5 cycles at t=10
        clr_stats();
        start_burst(1'b0, 4, 25);
        repeat (10) @(posedge clk);
        #1 wr = 1'b0;
        repeat (5) @(posedge clk);
        #1 wr = 1'b1;
        wait_idle(200);
        chk("t4_stall_rd", 64'(stall_rd), 64'd0);
        chk("t4_done_cyc", 64'(done_cyc), 64'(s_cyc + 37));
        for (int l = 0; l < L; l += 6) begin
            chk("t4_rd", 64'(rd_cnt[l]), 64'd4);
            chk("t4_beats", 64'(beat_n[l]), 64'd4);
        end

        // abort at t=6
        clr_stats();
        start_burst(1'b0, 4, 25);
        repeat (6) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_valid", 64'(dvalid), 64'd0);
        chk("t5_rden", 64'(rden), 64'd0);
        chk("t5_last", 64'(blast), 64'd0);
        repeat (30) @(negedge clk);
        chk("t5_done_n", 64'(done_cnt), 64'd0);
        chk("t5_rd5", 64'(rd_cnt[5]), 64'd1);
        chk("t5_rd6", 64'(rd_cnt[6]), 64'd0);

        // async reset while draining, then a clean burst
        clr_stats();
        start_burst(1'b0, 4, 25);
        repeat (29) @(posedge clk);
        #1;
        chk("t6_pre_valid", 64'(dvalid[24]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_valid", 64'(dvalid), 64'd0);
        chk("t6_data", 64'(|sdata), 64'd0);
        chk("t6_addr", 64'(|baddr), 64'd0);
        chk("t6_last", 64'(blast), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clr_stats();
        start_burst(1'b0, 4, 25);
        wait_idle(200);
        sum = 0;
        for (int l = 0; l < L; l++) sum += beat_n[l];
        chk("t6_beats", 64'(sum), 64'd100);
        chk("t6_done_cyc", 64'(done_cyc), 64'(s_cyc + 32));
        chk("t6_done_n", 64'(done_cnt), 64'd1);

        // zero-length burst
        clr_stats();
        start_burst(1'b0, 0, 25);
        chk("t7_done_now", 64'(done), 64'd1);
        wait_idle(20);
        sum = 0;
        for (int l = 0; l < L; l++) sum += rd_cnt[l];
        chk("t7_rd", 64'(sum), 64'd0);
        chk("t7_done_cyc", 64'(done_cyc), 64'(s_cyc + 1));
        chk("t7_done_n", 64'(done_cnt), 64'd1);

        // max burst on a single lane, with a start while busy
        clr_stats();
        start_burst(1'b0, 1024, 1);
        repeat (100) @(posedge clk);
        #1;
        mode = 1'b1;
        blen = (AW+1)'(5);
        act = (LW+1)'(25);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(3000);
        sum = 0;
        for (int l = 1; l < L; l++) sum += rd_cnt[l];
        chk("t8_rd0", 64'(rd_cnt[0]), 64'd1024);
        chk("t8_beats0", 64'(beat_n[0]), 64'd1024);
        chk("t8_rd_other", 64'(sum), 64'd0);
        chk("t8_addr_end", 64'(baddr[0]), 64'd1023);
        chk("t8_done_cyc", 64'(done_cyc), 64'(s_cyc + 1028));
        chk("t8_done_n", 64'(done_cnt), 64'd1);
        chk("t8_last_n", 64'(last_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
